// File: rtl/result_broadcaster.sv
// ---------------------------------------------------------------------------
// result_broadcaster
// Common-data-bus driver. Each of NUM_SRC functional units hands completed
// results (tag + data) into its own one-entry holding slot. A round-robin
// arbiter drains at most one slot per cycle into a registered broadcast port
// that feeds the rename table. The broadcast consumer never stalls.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   flush_IN       discard all held results, suppress accept and grant
//   src_valid_IN   per-source result offer
//   src_ready_OUT  per-source accept (combinational: slot empty or draining)
//   src_tag_IN     packed source tags,  source i at [i*tag_width  +: tag_width]
//   src_data_IN    packed source data,  source i at [i*data_width +: data_width]
//   bcast_OUT      one-cycle strobe per broadcast result
//   bcast_tag_OUT  broadcast tag (holds when no strobe)
//   d_OUT          broadcast data (holds when no strobe)
//   pending_OUT    registered count of occupied slots
// ---------------------------------------------------------------------------
module result_broadcaster #(
    parameter int unsigned tag_width  = 8,
    parameter int unsigned data_width = 128,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_IN,
    input  logic [NUM_SRC-1:0]            src_valid_IN,
    output logic [NUM_SRC-1:0]            src_ready_OUT,
    input  logic [NUM_SRC*tag_width-1:0]  src_tag_IN,
    input  logic [NUM_SRC*data_width-1:0] src_data_IN,
    output logic                          bcast_OUT,
    output logic [tag_width-1:0]          bcast_tag_OUT,
    output logic [data_width-1:0]         d_OUT,
    output logic [CNT_W-1:0]              pending_OUT
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Holding slots
    logic [NUM_SRC-1:0]    slot_v_q;
    logic [NUM_SRC-1:0]    slot_v_d;
    logic [tag_width-1:0]  slot_tag_q  [NUM_SRC];
    logic [data_width-1:0] slot_data_q [NUM_SRC];

    // Round-robin pointer
    logic [PTR_W-1:0] rr_q;
    logic [PTR_W-1:0] rr_d;

    // Broadcast output register
    logic                  bcast_q;
    logic                  bcast_d;
    logic [tag_width-1:0]  bcast_tag_q;
    logic [tag_width-1:0]  bcast_tag_d;
    logic [data_width-1:0] d_q;
    logic [data_width-1:0] d_d;

    // Occupancy count
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;

    // Arbiter results
    logic [NUM_SRC-1:0] grant_c;
    logic [PTR_W-1:0]   gnt_idx_c;
    logic               gnt_any_c;
    logic [NUM_SRC-1:0] accept_c;

    // Round-robin search starting at rr_q, wrapping; flush suppresses any grant.
    always_comb begin
        int unsigned idx;
        grant_c   = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        idx       = 0;
        if (!flush_IN) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                idx = (32'(rr_q) + k) % NUM_SRC;
                if (!gnt_any_c && slot_v_q[PTR_W'(idx)]) begin
                    gnt_any_c               = 1'b1;
                    gnt_idx_c               = PTR_W'(idx);
                    grant_c[PTR_W'(idx)]    = 1'b1;
                end
            end
        end
    end

    // A slot can take a new result when empty or when it is draining this cycle.
    assign src_ready_OUT = ~slot_v_q | grant_c;
    assign accept_c      = src_valid_IN & src_ready_OUT & {NUM_SRC{~flush_IN}};

    // Slot occupancy next state: flush > accept (incl. reload on grant) > grant.
    always_comb begin
        slot_v_d = slot_v_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (flush_IN) begin
                slot_v_d[i] = 1'b0;
            end else if (accept_c[i]) begin
                slot_v_d[i] = 1'b1;
            end else if (grant_c[i]) begin
                slot_v_d[i] = 1'b0;
            end
        end
    end

    // Pointer advances past the granted slot, otherwise holds.
    always_comb begin
        rr_d = rr_q;
        if (gnt_any_c) begin
            if (gnt_idx_c == PTR_W'(NUM_SRC - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_idx_c + PTR_W'(1);
            end
        end
    end

    // Broadcast register: strobe follows the grant, payload holds otherwise.
    always_comb begin
        bcast_d     = gnt_any_c;
        bcast_tag_d = bcast_tag_q;
        d_d         = d_q;
        if (gnt_any_c) begin
            bcast_tag_d = slot_tag_q[gnt_idx_c];
            d_d         = slot_data_q[gnt_idx_c];
        end
    end

    // pending tracks the slot occupancy that becomes current at the same edge.
    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pending_d = pending_d + CNT_W'(slot_v_d[i]);
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q    <= '0;
            rr_q        <= '0;
            bcast_q     <= 1'b0;
            bcast_tag_q <= '0;
            d_q         <= '0;
            pending_q   <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            rr_q        <= rr_d;
            bcast_q     <= bcast_d;
            bcast_tag_q <= bcast_tag_d;
            d_q         <= d_d;
            pending_q   <= pending_d;
        end
    end

    // Slot payloads are only observed while their valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (accept_c[i]) begin
                slot_tag_q[i]  <= src_tag_IN[i*tag_width +: tag_width];
                slot_data_q[i] <= src_data_IN[i*data_width +: data_width];
            end
        end
    end

    assign bcast_OUT     = bcast_q;
    assign bcast_tag_OUT = bcast_tag_q;
    assign d_OUT         = d_q;
    assign pending_OUT   = pending_q;

`ifndef SYNTHESIS
    // Sanity: single grant, count within range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_c))
                else $error("result_broadcaster: multiple grants");
            assert (32'(pending_q) <= NUM_SRC)
                else $error("result_broadcaster: pending out of range");
        end
    end
`endif

endmodule

// File: tb/tb_result_broadcaster.sv
// ---------------------------------------------------------------------------
// tb_result_broadcaster
// Directed test of result_broadcaster (NUM_SRC=4, tag 8b, data 128b) with
// hand-computed expected broadcasts, occupancy and ready values.
// ---------------------------------------------------------------------------
module tb_result_broadcaster;

    localparam int unsigned TW = 8;
    localparam int unsigned DW = 128;
    localparam int unsigned NS = 4;
    localparam int unsigned CW = 3;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [NS-1:0]      src_valid;
    logic [NS-1:0]      src_ready;
    logic [NS*TW-1:0]   src_tag;
    logic [NS*DW-1:0]   src_data;
    logic               bcast;
    logic [TW-1:0]      bcast_tag;
    logic [DW-1:0]      d_out;
    logic [CW-1:0]      pending;

    int n_checks;
    int n_fail;

    result_broadcaster #(
        .tag_width  (TW),
        .data_width (DW),
        .NUM_SRC    (NS),
        .CNT_W      (CW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush_IN      (flush),
        .src_valid_IN  (src_valid),
        .src_ready_OUT (src_ready),
        .src_tag_IN    (src_tag),
        .src_data_IN   (src_data),
        .bcast_OUT     (bcast),
        .bcast_tag_OUT (bcast_tag),
        .d_OUT         (d_out),
        .pending_OUT   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input logic [TW-1:0] t);
        return {16{t}};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [TW-1:0] t);
        src_valid[i]          = 1'b1;
        src_tag[i*TW +: TW]   = t;
        src_data[i*DW +: DW]  = dat(t);
    endtask

    task automatic clr_src();
        src_valid = '0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        clr_src();
        step();
        rst   = 1'b0;
    endtask

    task automatic chk_bc(input string name, input logic [TW-1:0] t);
        check_val({name, "_v"},   128'(bcast), 128'(1'b1));
        check_val({name, "_tag"}, 128'(bcast_tag), 128'(t));
        check_val({name, "_d"},   d_out, dat(t));
    endtask

    logic [TW-1:0] seq [4];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
        seq[0] = 8'h10; seq[1] = 8'h20; seq[2] = 8'h30; seq[3] = 8'h40;

        // 1: single result, reset state and latency
        do_reset();
        check_val("rst_bcast",   128'(bcast), 128'(0));
        check_val("rst_tag",     128'(bcast_tag), 128'(0));
        check_val("rst_d",       d_out, 128'(0));
        check_val("rst_pending", 128'(pending), 128'(0));
        check_val("rst_ready",   128'(src_ready), 128'(4'hF));
        set_src(0, 8'h11);
        #1;
        check_val("t1_ready0", 128'(src_ready[0]), 128'(1));
        step();
        clr_src();
        check_val("t1_pend1",  128'(pending), 128'(1));
        check_val("t1_nobc",   128'(bcast), 128'(0));
        step();
        chk_bc("t1_bc", 8'h11);
        step();
        check_val("t1_bc_off",  128'(bcast), 128'(0));
        check_val("t1_pend0",   128'(pending), 128'(0));
        check_val("t1_taghold", 128'(bcast_tag), 128'(8'h11));

        // 2: all sources continuously valid, full-rate round robin
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, seq[i]);
        step();
        check_val("t2_pend4", 128'(pending), 128'(4));
        check_val("t2_ready", 128'(src_ready), 128'(4'b0001));
        for (int k = 0; k < 8; k++) begin
            step();
            chk_bc($sformatf("t2_bc%0d", k), seq[k % 4]);
            check_val($sformatf("t2_rdy%0d", k), 128'(src_ready), 128'(4'b0001 << ((k + 1) % 4)));
        end
        clr_src();

        // 3: src2 waits behind slots 0,1 and completes on its own grant
        do_reset();
        set_src(0, 8'h10);
        set_src(1, 8'h20);
        set_src(2, 8'h30);
        step();
        clr_src();
        set_src(2, 8'h33);
        #1;
        check_val("t3_rdy2_a", 128'(src_ready[2]), 128'(0));
        step();
        chk_bc("t3_bc0", 8'h10);
        check_val("t3_rdy2_b", 128'(src_ready[2]), 128'(0));
        step();
        chk_bc("t3_bc1", 8'h20);
        check_val("t3_rdy2_c", 128'(src_ready[2]), 128'(1));
        step();
        clr_src();
        chk_bc("t3_bc2", 8'h30);
        check_val("t3_pend", 128'(pending), 128'(1));
        step();
        chk_bc("t3_bc3", 8'h33);
        step();
        check_val("t3_idle", 128'(bcast), 128'(0));

        // 4: flush discards held results and the accept offered with it
        do_reset();
        set_src(0, 8'h50);
        set_src(1, 8'h60);
        set_src(2, 8'h70);
        step();
        clr_src();
        check_val("t4_pend3", 128'(pending), 128'(3));
        flush = 1'b1;
        set_src(3, 8'h77);
        step();
        flush = 1'b0;
        clr_src();
        check_val("t4_pend0", 128'(pending), 128'(0));
        check_val("t4_nobc",  128'(bcast), 128'(0));
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("t4_quiet%0d", k), 128'(bcast), 128'(0));
        end
        check_val("t4_pend_end", 128'(pending), 128'(0));

        // 5: reset mid-operation drops held results and the live broadcast
        do_reset();
        set_src(0, 8'hA0);
        set_src(1, 8'hA1);
        set_src(3, 8'hA3);
        step();
        clr_src();
        step();
        chk_bc("t5_pre", 8'hA0);
        check_val("t5_pre_pend", 128'(pending), 128'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_bcast", 128'(bcast), 128'(0));
        check_val("t5_tag",   128'(bcast_tag), 128'(0));
        check_val("t5_d",     d_out, 128'(0));
        check_val("t5_pend",  128'(pending), 128'(0));
        set_src(3, 8'hB3);
        step();
        clr_src();
        set_src(0, 8'hB0);
        step();
        clr_src();
        chk_bc("t5_bc3", 8'hB3);
        step();
        chk_bc("t5_bc0", 8'hB0);
        step();
        check_val("t5_idle", 128'(bcast), 128'(0));

        // 6: wrap-around from p=2 to slot 1, pointer returns to 2
        do_reset();
        set_src(1, 8'hC1);
        step();
        clr_src();
        step();
        chk_bc("t6_first", 8'hC1);
        step();
        set_src(1, 8'hC2);
        step();
        clr_src();
        check_val("t6_pend1", 128'(pending), 128'(1));
        step();
        chk_bc("t6_wrap", 8'hC2);
        set_src(1, 8'hD1);
        set_src(2, 8'hD2);
        step();
        clr_src();
        step();
        chk_bc("t6_p2_first", 8'hD2);
        step();
        chk_bc("t6_p2_second", 8'hD1);
        step();
        check_val("t6_idle", 128'(bcast), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
